spi_reg_bank: RTL and testbench

// SPI-mode-0 slave and register bank that loads the network's 8-bit weight/input registers and reads back the 4-bit class result.

---
 rtl/spi_reg_bank.sv | 226 ++++++++++++++++++++++
 tb/tb_spi_reg_bank.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 slave feeding an 8-bit register bank.
// The first byte of a frame is {rw, addr}. rw=1 writes the following bytes
// to consecutive registers. rw=0 streams register contents back on MISO.
// All SPI pins are synchronised into clk, and every action happens on clk.
// Optional feature macro: SPI_READBACK_EN. When it is defined, the MISO read
// path is built. When it is undefined, MISO stays 0 and no read shifter exists.
module spi_reg_bank #(
  parameter int NUM_REGS    = 121,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SCK,
  input  logic                  CS,
  input  logic                  MOSI,
  output logic                  MISO,
  input  logic [3:0]            regr_0,
  output logic [NUM_REGS*8-1:0] regs_flat,
  output logic                  wr_pulse,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic                  frame_active
);

  localparam logic [ADDR_W-1:0] STATUS_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] NUM_REGS_A  = ADDR_W'(NUM_REGS);
  localparam logic [ADDR_W-1:0] ADDR_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WDATA = 2'd2,
    ST_RDATA = 2'd3
  } state_t;

  state_t                  state_r, state_nx_s;
  logic [SYNC_STAGES-1:0]  sck_sync_r, cs_sync_r, mosi_sync_r;
  logic                    sck_d_r, cs_d_r;
  logic                    sck_s, cs_s, mosi_s;
  logic                    sck_rise_s, sck_fall_s, cs_fall_s, cs_rise_s;
  logic [2:0]              bitcnt_r;
  logic [7:0]              shift_r;
  logic [7:0]              rx_byte_s;
  logic [ADDR_W-1:0]       addr_r, addr_inc_s;
  logic [7:0]              regs_r [NUM_REGS];
  logic                    wr_pulse_r, frame_active_r;
  logic [ADDR_W-1:0]       wr_addr_r;
  logic                    start_s, abort_s, bit_s, byte_done_s, shift_out_s;
  logic                    cmd_done_s, wr_done_s, wr_commit_s, rd_next_s;

  // Bring the asynchronous SPI pins into clk. CS resets high, so a reset never looks like a frame start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_sync_r  <= {SYNC_STAGES{1'b0}};
      cs_sync_r   <= {SYNC_STAGES{1'b1}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      sck_d_r     <= 1'b0;
      cs_d_r      <= 1'b1;
    end else begin
      sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], SCK};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], CS};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], MOSI};
      sck_d_r     <= sck_sync_r[SYNC_STAGES-1];
      cs_d_r      <= cs_sync_r[SYNC_STAGES-1];
    end
  end

  assign sck_s      = sck_sync_r[SYNC_STAGES-1];
  assign cs_s       = cs_sync_r[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync_r[SYNC_STAGES-1];
  assign sck_rise_s = sck_s & ~sck_d_r;
  assign sck_fall_s = ~sck_s & sck_d_r;
  assign cs_fall_s  = ~cs_s & cs_d_r;
  assign cs_rise_s  = cs_s & ~cs_d_r;

  // The byte as it stands once the current MOSI bit is shifted in.
  assign rx_byte_s  = {shift_r[6:0], mosi_s};
  // The address saturates at the status address and never wraps to 0.
  assign addr_inc_s = (addr_r == STATUS_ADDR) ? addr_r : (addr_r + ADDR_ONE);

  // Frame state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic. A CS rise beats any SCK event in the same cycle.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cs_fall_s) state_nx_s = ST_CMD;
        else           state_nx_s = ST_IDLE;
      end
      ST_CMD: begin
        if (abort_s)         state_nx_s = ST_IDLE;
        else if (cmd_done_s) state_nx_s = rx_byte_s[7] ? ST_WDATA : ST_RDATA;
        else                 state_nx_s = ST_CMD;
      end
      ST_WDATA, ST_RDATA: begin
        if (abort_s) state_nx_s = ST_IDLE;
        else         state_nx_s = state_r;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Per-cycle action strobes decoded from the state and the synchronised edges.
  // An SCK rise that coincides with the CS fall is ignored, because the rise arrives while the FSM is still idle.
  always_comb begin
    start_s     = 1'b0;
    abort_s     = 1'b0;
    bit_s       = 1'b0;
    shift_out_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        start_s = cs_fall_s;
      end
      ST_CMD, ST_WDATA, ST_RDATA: begin
        if (cs_rise_s) begin
          abort_s = 1'b1;
        end else begin
          bit_s       = sck_rise_s;
          shift_out_s = (state_r == ST_RDATA) & sck_fall_s & (bitcnt_r != 3'd0);
        end
      end
      default: begin
        start_s = 1'b0;
      end
    endcase
    byte_done_s = bit_s & (bitcnt_r == 3'd7);
    cmd_done_s  = byte_done_s & (state_r == ST_CMD);
    wr_done_s   = byte_done_s & (state_r == ST_WDATA);
    wr_commit_s = wr_done_s & (addr_r < NUM_REGS_A);
    rd_next_s   = byte_done_s & (state_r == ST_RDATA);
  end

  // Bit counter, receive shifter, address counter, register file and write strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bitcnt_r       <= 3'd0;
      shift_r        <= 8'h00;
      addr_r         <= {ADDR_W{1'b0}};
      wr_pulse_r     <= 1'b0;
      wr_addr_r      <= {ADDR_W{1'b0}};
      frame_active_r <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= 8'h00;
    end else begin
      wr_pulse_r <= 1'b0;
      if (start_s) begin
        bitcnt_r       <= 3'd0;
        frame_active_r <= 1'b1;
      end else if (abort_s) begin
        bitcnt_r       <= 3'd0;
        frame_active_r <= 1'b0;
      end else if (bit_s) begin
        shift_r  <= rx_byte_s;
        bitcnt_r <= bitcnt_r + 3'd1;
        if (cmd_done_s) begin
          addr_r <= rx_byte_s[ADDR_W-1:0];
        end else if (wr_done_s || rd_next_s) begin
          addr_r <= addr_inc_s;
        end
        if (wr_commit_s) begin
          regs_r[addr_r] <= rx_byte_s;
          wr_pulse_r     <= 1'b1;
          wr_addr_r      <= addr_r;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[8*g +: 8] = regs_r[g];
  end

  assign wr_pulse     = wr_pulse_r;
  assign wr_addr      = wr_addr_r;
  assign frame_active = frame_active_r;

`ifdef SPI_READBACK_EN
  logic [7:0]        rd_shift_r;
  logic              miso_r;
  logic              rd_load_s;
  logic [ADDR_W-1:0] rd_addr_s;

  // Read map: register, 0x00 hole above the register file, and the status byte at the top address.
  function automatic logic [7:0] read_map(input logic [ADDR_W-1:0] a);
    logic [7:0] v;
    if (a < NUM_REGS_A)         v = regs_r[a];
    else if (a == STATUS_ADDR)  v = {4'b0000, regr_0};
    else                        v = 8'h00;
    return v;
  endfunction

  assign rd_load_s = (cmd_done_s & ~rx_byte_s[7]) | rd_next_s;
  assign rd_addr_s = cmd_done_s ? rx_byte_s[ADDR_W-1:0] : addr_inc_s;

  // Read shifter. A byte loads right after the previous byte completes, and its MSB is put on MISO at that point.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_shift_r <= 8'h00;
      miso_r     <= 1'b0;
    end else if (start_s || abort_s) begin
      rd_shift_r <= 8'h00;
      miso_r     <= 1'b0;
    end else if (rd_load_s) begin
      rd_shift_r <= read_map(rd_addr_s);
      miso_r     <= read_map(rd_addr_s) >> 7;
    end else if (shift_out_s) begin
      rd_shift_r <= {rd_shift_r[6:0], 1'b0};
      miso_r     <= rd_shift_r[6];
    end
  end

  assign MISO = miso_r;
`else
  logic unused_s;
  assign unused_s = ^{regr_0, shift_out_s};
  assign MISO     = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank. It drives the directed frames first, then random
// write and read frames. A register array model predicts the register file contents, the
// sequence of write strobes, and the bytes read back on MISO.
module tb_spi_reg_bank;
  localparam int NUM_REGS = 121;
  localparam int ADDR_W   = 7;
  localparam int HALF     = 60;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  SCK = 1'b0;
  logic                  CS = 1'b1;
  logic                  MOSI = 1'b0;
  logic [3:0]            regr_0 = 4'd0;
  logic                  MISO;
  logic [NUM_REGS*8-1:0] regs_flat;
  logic                  wr_pulse;
  logic [ADDR_W-1:0]     wr_addr;
  logic                  frame_active;

  spi_reg_bank #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .SCK(SCK), .CS(CS), .MOSI(MOSI), .MISO(MISO),
    .regr_0(regr_0), .regs_flat(regs_flat), .wr_pulse(wr_pulse),
    .wr_addr(wr_addr), .frame_active(frame_active)
  );

  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] mregs [NUM_REGS];
  logic [7:0] tx_buf [8];
  logic [7:0] rx_buf [8];
  logic [7:0] exp_rx [8];
  int         wr_obs[$];
  int         wr_exp[$];
  logic [7:0] dummy;

  always @(negedge clk) if (rst && wr_pulse) wr_obs.push_back(int'(wr_addr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    logic [NUM_REGS*8-1:0] exp_flat;
    int first;
    for (int i = 0; i < NUM_REGS; i++) exp_flat[8*i +: 8] = mregs[i];
    vectors++;
    assert (regs_flat === exp_flat) else begin
      miscompares++;
      first = 0;
      for (int i = NUM_REGS-1; i >= 0; i--) if (regs_flat[8*i +: 8] !== exp_flat[8*i +: 8]) first = i;
      $error("FAIL %s_regs: reg %0d observed 0x%02h expected 0x%02h", tag, first,
             regs_flat[8*first +: 8], exp_flat[8*first +: 8]);
    end
  endtask

  function automatic logic [7:0] model_read(input int a);
`ifdef SPI_READBACK_EN
    if (a < NUM_REGS) return mregs[a];
    if (a == 127) return {4'd0, regr_0};
    return 8'h00;
`else
    return 8'h00;
`endif
  endfunction

  // Applies a frame of n complete bytes from tx_buf to the model.
  task automatic model_frame(input int n);
    int a;
    a = int'(tx_buf[0][6:0]);
    for (int k = 1; k < n; k++) begin
      if (tx_buf[0][7]) begin
        if (a < NUM_REGS) begin
          mregs[a] = tx_buf[k];
          wr_exp.push_back(a);
        end
      end else begin
        exp_rx[k] = model_read(a);
      end
      if (a < 127) a++;
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - n; i--) begin
      MOSI = tx[i];
      #(HALF);
      SCK = 1'b1;
      rx[i] = MISO;
      #(HALF);
      SCK = 1'b0;
    end
  endtask

  task automatic run_frame(input int n);
    @(negedge clk);
    CS = 1'b0;
    #(HALF);
    chk("frame_active_hi", 32'(frame_active), 32'd1);
    for (int k = 0; k < n; k++) spi_bits(tx_buf[k], 8, rx_buf[k]);
    #(HALF);
    CS = 1'b1;
    #(2*HALF);
  endtask

  task automatic check_frame(input string tag, input int n);
    int cnt;
    if (!tx_buf[0][7])
      for (int k = 1; k < n; k++) chk($sformatf("%s_rx%0d", tag, k), 32'(rx_buf[k]), 32'(exp_rx[k]));
    chk({tag, "_wrcnt"}, wr_obs.size(), wr_exp.size());
    cnt = (wr_obs.size() < wr_exp.size()) ? wr_obs.size() : wr_exp.size();
    for (int k = 0; k < cnt; k++) chk($sformatf("%s_wraddr%0d", tag, k), wr_obs[k], wr_exp[k]);
    wr_obs.delete();
    wr_exp.delete();
    check_regs(tag);
    chk({tag, "_miso_idle"}, 32'(MISO), 32'd0);
    chk({tag, "_frame_active_lo"}, 32'(frame_active), 32'd0);
  endtask

  initial begin
    int n;
    int a;
    for (int i = 0; i < NUM_REGS; i++) mregs[i] = 8'h00;
    repeat (3) @(negedge clk);
    check_regs("reset");
    chk("reset_miso", 32'(MISO), 32'd0);
    chk("reset_wr_pulse", 32'(wr_pulse), 32'd0);
    chk("reset_wr_addr", 32'(wr_addr), 32'd0);
    chk("reset_frame_active", 32'(frame_active), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // T1 write burst
    tx_buf[0] = 8'h85; tx_buf[1] = 8'hAA; tx_buf[2] = 8'h55;
    run_frame(3); model_frame(3);
    chk("t1_wr_addr_last", 32'(wr_addr), 32'd6);
    check_frame("t1", 3);

    // T2 status read
    regr_0 = 4'd7;
    tx_buf[0] = 8'h7F; tx_buf[1] = 8'h00;
    run_frame(2); model_frame(2);
    check_frame("t2", 2);

    // T3 readback burst
    tx_buf[0] = 8'h05; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
    run_frame(3); model_frame(3);
    check_frame("t3", 3);

    // T4 boundary at the last register
    tx_buf[0] = 8'hF8; tx_buf[1] = 8'h11; tx_buf[2] = 8'h22; tx_buf[3] = 8'h33;
    run_frame(4); model_frame(4);
    check_frame("t4", 4);

    // T5 abort partway through a byte
    @(negedge clk);
    CS = 1'b0;
    #(HALF);
    spi_bits(8'h83, 8, dummy);
    spi_bits(8'hF0, 8, dummy);
    spi_bits(8'hAB, 4, dummy);
    #(HALF);
    CS = 1'b1;
    #(2*HALF);
    tx_buf[0] = 8'h83; tx_buf[1] = 8'hF0;
    model_frame(2);
    check_frame("t5a", 2);
    tx_buf[0] = 8'h84; tx_buf[1] = 8'h3C;
    run_frame(2); model_frame(2);
    check_frame("t5b", 2);

    // Random frames, biased toward the top of the address space
    for (int it = 0; it < 24; it++) begin
      regr_0 = 4'($urandom_range(0, 15));
      a = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 127) : $urandom_range(115, 127);
      n = $urandom_range(2, 5);
      tx_buf[0] = {1'($urandom_range(0, 1)), 7'(a)};
      for (int k = 1; k < n; k++) tx_buf[k] = 8'($urandom_range(0, 255));
      run_frame(n); model_frame(n);
      check_frame($sformatf("rnd%0d", it), n);
    end

    // T6 reset in the middle of a data byte
    @(negedge clk);
    CS = 1'b0;
    #(HALF);
    spi_bits(8'h8A, 8, dummy);
    spi_bits(8'h66, 4, dummy);
    #7;
    rst = 1'b0;
    #23;
    for (int i = 0; i < NUM_REGS; i++) mregs[i] = 8'h00;
    check_regs("t6_rst");
    chk("t6_miso", 32'(MISO), 32'd0);
    chk("t6_frame_active", 32'(frame_active), 32'd0);
    chk("t6_wr_pulse", 32'(wr_pulse), 32'd0);
    chk("t6_wr_addr", 32'(wr_addr), 32'd0);
    CS = 1'b1;
    MOSI = 1'b0;
    #40;
    @(negedge clk);
    rst = 1'b1;
    #20;
    wr_obs.delete();
    wr_exp.delete();
    tx_buf[0] = 8'h8A; tx_buf[1] = 8'h5A;
    run_frame(2); model_frame(2);
    check_frame("t6_after", 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
